// File: rtl/process_pkg.sv
// Shared definitions for the run controller and the cores: per-core status
// encodings and the controller FSM state type.
package process_pkg;

    localparam int unsigned CORE_STATUS_W = 2;

    localparam logic [CORE_STATUS_W-1:0] ST_IDLE = 2'b00;
    localparam logic [CORE_STATUS_W-1:0] ST_RUN  = 2'b01;
    localparam logic [CORE_STATUS_W-1:0] ST_ACK  = 2'b10;

    typedef enum logic [1:0] {
        PC_IDLE   = 2'd0,
        PC_LAUNCH = 2'd1,
        PC_WAIT   = 2'd2,
        PC_FINISH = 2'd3
    } pc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_enable && (o_count != '1)) begin
            o_count <= o_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/process_controller.sv
// Run controller for the core array: launches all enabled cores on start, waits
// for every one to report end_process, then pulses done and returns to idle.
// Optional watchdog enabled by defining PROCESS_CONTROLLER_TIMEOUT_EN.
module process_controller
    import process_pkg::*;
#(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_CORES-1:0]              core_mask,
    input  logic [NUM_CORES-1:0]              end_process,
    output logic [CORE_STATUS_W*NUM_CORES-1:0] status,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout,
    output logic [CNT_W-1:0]                  cycle_count
);

    localparam int unsigned STATUS_W = CORE_STATUS_W * NUM_CORES;

    pc_state_e            r_state;
    logic [NUM_CORES-1:0] r_mask;
    logic [NUM_CORES-1:0] r_finished;

    logic [NUM_CORES-1:0] w_captured;
    logic                 w_all_done;
    logic                 w_cnt_clear;
    logic                 w_cnt_en;
    logic                 w_watchdog;

    // Drive code to every selected core, IDLE to the rest.
    function automatic logic [STATUS_W-1:0] fan_status(
        input logic [NUM_CORES-1:0]     sel,
        input logic [CORE_STATUS_W-1:0] code
    );
        logic [STATUS_W-1:0] v;
        v = {NUM_CORES{ST_IDLE}};
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (sel[i]) begin
                v[CORE_STATUS_W*i +: CORE_STATUS_W] = code;
            end
        end
        return v;
    endfunction

    always_comb begin
        w_captured  = end_process & r_mask;
        w_all_done  = ((r_finished | w_captured) == r_mask);
        w_cnt_clear = (r_state == PC_IDLE) && start;
        w_cnt_en    = (r_state == PC_LAUNCH) || (r_state == PC_WAIT);
    end

`ifdef PROCESS_CONTROLLER_TIMEOUT_EN
    // Fires on the WAIT cycle whose increment brings the count to the limit.
    assign w_watchdog = (r_state == PC_WAIT) &&
                        (cycle_count >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_watchdog       = 1'b0;
`endif

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cycle_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_cnt_clear),
        .i_enable(w_cnt_en),
        .o_count (cycle_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= PC_IDLE;
            r_mask     <= '0;
            r_finished <= '0;
            status     <= {NUM_CORES{ST_IDLE}};
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                PC_IDLE: begin
                    if (start) begin
                        r_state    <= PC_LAUNCH;
                        r_mask     <= core_mask;
                        r_finished <= '0;
                        timeout    <= 1'b0;
                        busy       <= 1'b1;
                        status     <= fan_status(core_mask, ST_RUN);
                    end
                end
                // end_process is deliberately ignored here to drop stale levels.
                PC_LAUNCH: begin
                    if (r_mask == '0) begin
                        r_state <= PC_FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        status  <= fan_status(r_mask, ST_ACK);
                    end else begin
                        r_state <= PC_WAIT;
                    end
                end
                PC_WAIT: begin
                    r_finished <= r_finished | w_captured;
                    if (w_all_done || w_watchdog) begin
                        r_state <= PC_FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= ~w_all_done;
                        status  <= fan_status(r_mask, ST_ACK);
                    end
                end
                PC_FINISH: begin
                    r_state <= PC_IDLE;
                    status  <= {NUM_CORES{ST_IDLE}};
                end
                default: begin
                    r_state <= PC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_process_controller.sv
// Randomised bench for process_controller: each run is described by per-core
// finish cycles and checked cycle by cycle against the expected run length.
module tb_process_controller;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned TO = 20;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [N-1:0]   core_mask;
    logic [N-1:0]   end_process;
    logic [2*N-1:0] status;
    logic           busy;
    logic           done;
    logic           timeout;
    logic [CW-1:0]  cycle_count;

    logic [2*N-1:0] s_status;
    logic           s_busy;
    logic           s_done;
    logic           s_timeout;
    logic [2:0]     s_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int           fin [N];
    bit           pulse [N];
    logic [N-1:0] stale;
    bit           noise_hi;
    int           rst_at;

    always #5 clock = ~clock;

    process_controller #(
        .NUM_CORES(N), .CNT_W(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .core_mask(core_mask),
        .end_process(end_process), .status(status), .busy(busy), .done(done),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    // Narrow counter copy exposes saturation within a short run.
    process_controller #(
        .NUM_CORES(N), .CNT_W(3), .TIMEOUT_CYCLES(TO)
    ) dut_sat (
        .clock(clock), .reset(reset), .start(start), .core_mask(core_mask),
        .end_process(end_process), .status(s_status), .busy(s_busy), .done(s_done),
        .timeout(s_timeout), .cycle_count(s_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] exp_status(input logic [N-1:0] m, input logic [1:0] code);
        logic [2*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (m[i]) v[2*i +: 2] = code;
        return v;
    endfunction

    task automatic cfg(input int f0, input int f1, input int f2, input int f3,
                       input logic [N-1:0] pl, input logic [N-1:0] st,
                       input bit nh, input int ra);
        fin[0] = f0; fin[1] = f1; fin[2] = f2; fin[3] = f3;
        for (int i = 0; i < N; i++) pulse[i] = pl[i];
        stale = st; noise_hi = nh; rst_at = ra;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_status"}, 64'(status), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_count"}, 64'(cycle_count), 64'd0);
        check({tag, "_count_sat"}, 64'(s_count), 64'd0);
    endtask

    // One run: last masked finish cycle f gives f+1 counted cycles (watchdog caps it).
    task automatic do_run(input logic [N-1:0] m);
        int f;
        int e;
        bit exp_to;
        logic [N-1:0] ep;
        f = 0;
        for (int i = 0; i < N; i++) if (m[i] && fin[i] > f) f = fin[i];
        e = f + 1;
        exp_to = 1'b0;
`ifdef PROCESS_CONTROLLER_TIMEOUT_EN
        if (e > int'(TO)) begin
            e = int'(TO);
            exp_to = 1'b1;
        end
`endif
        core_mask = m;
        start = 1'b1;
        @(posedge clock); #1;
        for (int c = 0; c < e; c++) begin
            check("run_busy", 64'(busy), 64'd1);
            check("run_done", 64'(done), 64'd0);
            check("run_status", 64'(status), 64'(exp_status(m, 2'b01)));
            check("run_count", 64'(cycle_count), 64'(c));
            check("run_timeout", 64'(timeout), 64'd0);
`ifndef PROCESS_CONTROLLER_TIMEOUT_EN
            check("run_count_sat", 64'(s_count), 64'((c > 7) ? 7 : c));
`endif
            if (c == rst_at) begin
                reset = 1'b1;
                start = 1'b0;
                @(posedge clock); #1;
                check_zero("midrun_reset");
                reset = 1'b0;
                return;
            end
            start = 1'($urandom_range(0, 1));
            core_mask = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!m[i]) ep[i] = noise_hi ? 1'b1 : 1'($urandom_range(0, 1));
                else if (c == 0) ep[i] = stale[i];
                else if (pulse[i]) ep[i] = (c == fin[i]);
                else ep[i] = (c >= fin[i]);
            end
            end_process = ep;
            @(posedge clock); #1;
        end
        check("fin_done", 64'(done), 64'd1);
        check("fin_busy", 64'(busy), 64'd0);
        check("fin_status", 64'(status), 64'(exp_status(m, 2'b10)));
        check("fin_count", 64'(cycle_count), 64'(e));
        check("fin_timeout", 64'(timeout), 64'(exp_to));
`ifndef PROCESS_CONTROLLER_TIMEOUT_EN
        check("fin_count_sat", 64'(s_count), 64'((e > 7) ? 7 : e));
`endif
        start = 1'b0;
        end_process = N'($urandom);
        @(posedge clock); #1;
        check("idle_done", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_status", 64'(status), 64'd0);
        check("idle_count", 64'(cycle_count), 64'(e));
        check("idle_timeout", 64'(timeout), 64'(exp_to));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        core_mask = '0;
        end_process = '0;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        cfg(3, 5, 5, 9, 4'b0000, 4'b0000, 1'b0, -1);
        do_run(4'b1111);
        cfg(2, 1, 6, 1, 4'b0000, 4'b0000, 1'b1, -1);
        do_run(4'b0101);
        cfg(4, 2, 7, 3, 4'b0101, 4'b1111, 1'b0, -1);
        do_run(4'b1111);
        cfg(8, 8, 8, 8, 4'b0000, 4'b0000, 1'b0, 4);
        do_run(4'b1111);
        cfg(2, 3, 1, 4, 4'b0000, 4'b1111, 1'b0, -1);
        do_run(4'b1111);
        cfg(1, 1, 1, 1, 4'b0000, 4'b1111, 1'b1, -1);
        do_run(4'b0000);
        cfg(1, 1, 1, 1, 4'b1111, 4'b0000, 1'b0, -1);
        do_run(4'b1000);
`ifdef PROCESS_CONTROLLER_TIMEOUT_EN
        cfg(3, 1000, 5, 2, 4'b0000, 4'b0000, 1'b0, -1);
        do_run(4'b1111);
        cfg(19, 2, 3, 4, 4'b0000, 4'b0000, 1'b0, -1);
        do_run(4'b1111);
`endif
        repeat (40) begin
            cfg(int'($urandom_range(1, 24)), int'($urandom_range(1, 24)),
                int'($urandom_range(1, 24)), int'($urandom_range(1, 24)),
                N'($urandom), N'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12)) : -1);
            do_run(N'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
